spi_master_tx: RTL
==================

SPI_MASTER_TX -- requirements
Module: spi_master_tx

Interface
REQ-001 Parameter CLK_DIV, default 4, system clocks per SCLK half-period; legal range 1..255.
REQ-002 i_clock  input  1  system clock; all sequential logic on rising edge.
REQ-003 i_reset_n  input  1  reset, asynchronous, active-low.
REQ-004 i_txByte  input  8  byte to transmit; sampled only at handshake.
REQ-005 i_txValid  input  1  upstream asserts while i_txByte is valid.
REQ-006 o_txReady  output  1  block can accept a byte this cycle.
REQ-007 o_sclk  output  1  SPI clock, CPOL=1 (idles high).
REQ-008 o_mosi  output  1  serial data, MSB first.
REQ-009 o_select  output  1  slave select, active-low.
REQ-010 o_done  output  1  one-cycle pulse at end of each byte.
REQ-011 o_busy  output  1  high from cycle after handshake until o_txReady returns high.

Function
REQ-012 Handshake SHALL occur on a rising edge where i_txValid=1 and o_txReady=1; i_txByte captured into an 8-bit shift register at that edge.
REQ-013 o_txReady SHALL be high only in IDLE; i_txValid outside IDLE SHALL be ignored with no effect on the transfer in progress.
REQ-014 States SHALL be IDLE, SETUP, SHIFT, HOLD, GAP; IDLE->SETUP on handshake, SETUP->SHIFT after CLK_DIV cycles, SHIFT->HOLD after 16 half-periods, HOLD->GAP after CLK_DIV cycles, GAP->IDLE after CLK_DIV cycles.
REQ-015 A half-period counter SHALL count 0..CLK_DIV-1 and wrap; each wrap ends a half-period.
REQ-016 Handshake at edge k: from cycle k+1, o_select=0, o_sclk=1, o_mosi=bit 7, o_busy=1, o_txReady=0.
REQ-017 SETUP SHALL hold these values for CLK_DIV cycles so o_mosi is stable before the first falling SCLK edge (CPHA=0).
REQ-018 In SHIFT, o_sclk SHALL toggle at each half-period end; first falling edge at cycle k+1+CLK_DIV, then alternating edges every CLK_DIV cycles.
REQ-019 o_mosi SHALL change only in the cycle o_sclk rises: after rising edge n (n=0..6) o_mosi=bit (6-n); after rising edge 7 o_mosi holds bit 0.
REQ-020 Exactly 8 falling and 8 rising SCLK edges per byte; the 8th rising edge at cycle k+1+16*CLK_DIV ends SHIFT with o_sclk=1.
REQ-021 HOLD SHALL keep o_select=0, o_sclk=1 for CLK_DIV cycles.
REQ-022 At cycle k+1+17*CLK_DIV, o_select=1, o_mosi=1, and o_done=1 for exactly that cycle.
REQ-023 GAP SHALL keep o_select=1 for CLK_DIV cycles; o_txReady=1 and o_busy=0 from cycle k+1+18*CLK_DIV.
REQ-024 Back-to-back: i_txValid held high SHALL handshake on the first IDLE cycle; minimum select-high time between bytes is CLK_DIV+1 cycles.
REQ-025 Changes to i_txByte after handshake SHALL not affect the byte being sent.
REQ-026 CLK_DIV=1 SHALL work with SCLK = i_clock/2 and identical edge ordering.
REQ-027 No output SHALL glitch; all outputs registered.

Reset
REQ-028 i_reset_n=0 SHALL immediately, without a clock, force IDLE: o_sclk=1, o_select=1, o_mosi=1, o_txReady=1, o_done=0, o_busy=0, counters and shift register 0.
REQ-029 Reset mid-transfer SHALL abort the byte with no o_done pulse; after release the first rising edge behaves as IDLE.
REQ-030 Release of i_reset_n with i_txValid=1 SHALL handshake on the first rising edge after release.

Verification
REQ-031 CLK_DIV=4, send 0xA5 -> MOSI sampled at the 8 SCLK falling edges reads 1,0,1,0,0,1,0,1; select low 68 cycles; o_done at cycle k+69.
REQ-032 CLK_DIV=1, bytes 0x00 then 0xFF with i_txValid held -> two frames, data correct, select high exactly 2 cycles between frames, two o_done pulses 19 cycles apart.
REQ-033 i_txByte changed 0x3C->0xC3 one cycle after handshake; extra i_txValid pulses during SHIFT -> 0x3C transmitted, single frame, single o_done.
REQ-034 Assert i_reset_n=0 mid-cycle after 3rd falling SCLK edge -> o_select=1, o_sclk=1 asynchronously, no o_done; next byte 0x81 sends correctly.
REQ-035 Protocol checker over random bytes/gaps, CLK_DIV in {1,2,7} -> o_mosi never changes while o_sclk is low or at a falling edge; 8 falling edges per select-low window.

Source files
------------

// File: rtl/spi_master_tx_if.sv
// Upstream byte handshake plus SPI pins of the byte-serialising SPI master.
// A byte transfers on a rising clock edge where i_txValid and o_txReady are both high; i_txByte must be stable while i_txValid is high.
interface spi_master_tx_if;
   logic [7:0] i_txByte;
   logic       i_txValid;
   logic       o_txReady;
   logic       o_sclk;
   logic       o_mosi;
   logic       o_select;
   logic       o_done;
   logic       o_busy;

   modport master (
      input  i_txByte, i_txValid,
      output o_txReady, o_sclk, o_mosi, o_select, o_done, o_busy
   );

   modport slave (
      output i_txByte, i_txValid,
      input  o_txReady, o_sclk, o_mosi, o_select, o_done, o_busy
   );
endinterface

// File: rtl/spi_master_tx.sv
// SPI mode 3-idle / CPHA=0 transmitter: one byte per handshake, MSB first,
// select framing with setup, hold and inter-byte gap of CLK_DIV cycles each.
module spi_master_tx #(
   parameter int CLK_DIV = 4
) (
   input  logic            i_clock,
   input  logic            i_reset_n,
   spi_master_tx_if.master bus,
   output logic [2:0]      o_dbg_state
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      HOLD  = 3'd3,
      GAP   = 3'd4
   } state_t;

   localparam logic [7:0] DIV_M1    = 8'(CLK_DIV - 1);
   localparam logic [3:0] LAST_EDGE = 4'd14;

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [3:0] edge_q, edge_d;
   logic [7:0] sh_q, sh_d;
   logic       sclk_q, sclk_d;
   logic       mosi_q, mosi_d;
   logic       sel_q, sel_d;
   logic       done_q, done_d;
   logic       ready_q, ready_d;
   logic       busy_q, busy_d;

   logic       wrap;
   logic [7:0] cnt_nxt;

   assign wrap    = (cnt_q == DIV_M1);
   assign cnt_nxt = wrap ? 8'd0 : cnt_q + 8'd1;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         edge_q  <= '0;
         sh_q    <= '0;
         sclk_q  <= 1'b1;
         mosi_q  <= 1'b1;
         sel_q   <= 1'b1;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         edge_q  <= edge_d;
         sh_q    <= sh_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         sel_q   <= sel_d;
         done_q  <= done_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      edge_d  = edge_q;
      sh_d    = sh_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      sel_d   = sel_q;
      done_d  = 1'b0;
      ready_d = ready_q;
      busy_d  = busy_q;

      case (state_q)
         IDLE: begin
            if (bus.i_txValid && ready_q) begin
               // sh_q holds only the bits not yet presented on mosi
               state_d = SETUP;
               cnt_d   = '0;
               mosi_d  = bus.i_txByte[7];
               sh_d    = {bus.i_txByte[6:0], 1'b0};
               sel_d   = 1'b0;
               sclk_d  = 1'b1;
               ready_d = 1'b0;
               busy_d  = 1'b1;
            end
         end
         SETUP: begin
            cnt_d = cnt_nxt;
            if (wrap) begin
               state_d = SHIFT;
               sclk_d  = 1'b0;
               edge_d  = '0;
            end
         end
         SHIFT: begin
            cnt_d = cnt_nxt;
            if (wrap) begin
               sclk_d = ~sclk_q;
               edge_d = edge_q + 4'd1;
               // data advances only on rising edges; the 8th rising edge keeps bit 0
               if (!sclk_q && (edge_q != LAST_EDGE)) begin
                  mosi_d = sh_q[7];
                  sh_d   = {sh_q[6:0], 1'b0};
               end
               if (edge_q == LAST_EDGE) begin
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            cnt_d = cnt_nxt;
            if (wrap) begin
               state_d = GAP;
               sel_d   = 1'b1;
               mosi_d  = 1'b1;
               done_d  = 1'b1;
            end
         end
         GAP: begin
            cnt_d = cnt_nxt;
            if (wrap) begin
               state_d = IDLE;
               ready_d = 1'b1;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            sclk_d  = 1'b1;
            mosi_d  = 1'b1;
            sel_d   = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign bus.o_txReady = ready_q;
   assign bus.o_sclk    = sclk_q;
   assign bus.o_mosi    = mosi_q;
   assign bus.o_select  = sel_q;
   assign bus.o_done    = done_q;
   assign bus.o_busy    = busy_q;
   assign o_dbg_state   = state_q;

endmodule
